// File: rtl/writeback_regfile.sv
// writeback_regfile: MIPS write-back stage plus 32x32 general-purpose register file.
// Selects the write-back value and commits it to the array. Serves two decode
// read ports that see a same-cycle write through a bypass. Also latches the
// pipeline halt, provides a registered debug read port and counts retired slots.
module writeback_regfile #(
  parameter int NB_DATA = 32,
  parameter int N_REGS  = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_step,
  input  logic [NB_DATA-1:0] i_mem_data,
  input  logic [NB_DATA-1:0] i_alu_res,
  input  logic [NB_DATA-1:0] i_pc_to_reg,
  input  logic [NB_ADDR-1:0] i_addr_reg_dst,
  input  logic               is_RegWrite,
  input  logic               is_MemtoReg,
  input  logic               is_write_pc,
  input  logic               is_stop_pipe,
  input  logic [NB_ADDR-1:0] i_rs_addr,
  input  logic [NB_ADDR-1:0] i_rt_addr,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data,
  output logic [NB_DATA-1:0] o_wb_data,
  output logic               os_halted,
  output logic [31:0]        o_retired_count
);

  localparam logic [NB_ADDR-1:0] ADDR_ZERO = {NB_ADDR{1'b0}};
  localparam logic [NB_DATA-1:0] DATA_ZERO = {NB_DATA{1'b0}};

  logic [NB_DATA-1:0] regs_r [N_REGS];
  logic               halted_r;
  logic [31:0]        count_r;
  logic [NB_DATA-1:0] dbg_r;

  logic [NB_DATA-1:0] wb_data_s;
  logic [NB_DATA-1:0] rs_data_s;
  logic [NB_DATA-1:0] rt_data_s;
  logic               we_s;
  logic               advance_s;

  // Write-back source select: link address has priority over load data over ALU result.
  always_comb begin
    wb_data_s = i_alu_res;
    if (is_write_pc) begin
      wb_data_s = i_pc_to_reg;
    end else if (is_MemtoReg) begin
      wb_data_s = i_mem_data;
    end else begin
      wb_data_s = i_alu_res;
    end
  end

  // Slot advance and commit enable; r0 is never written and a halted pipe is frozen.
  always_comb begin
    advance_s = rst & i_step & ~halted_r;
    we_s      = advance_s & is_RegWrite & (i_addr_reg_dst != ADDR_ZERO);
  end

  // Decode read ports: r0 reads zero, a same-cycle write to the address is bypassed.
  always_comb begin
    rs_data_s = DATA_ZERO;
    rt_data_s = DATA_ZERO;
    if (i_rs_addr == ADDR_ZERO) begin
      rs_data_s = DATA_ZERO;
    end else if (we_s && (i_rs_addr == i_addr_reg_dst)) begin
      rs_data_s = wb_data_s;
    end else begin
      rs_data_s = regs_r[i_rs_addr];
    end
    if (i_rt_addr == ADDR_ZERO) begin
      rt_data_s = DATA_ZERO;
    end else if (we_s && (i_rt_addr == i_addr_reg_dst)) begin
      rt_data_s = wb_data_s;
    end else begin
      rt_data_s = regs_r[i_rt_addr];
    end
  end

  // Register array: cleared on reset, one write per enabled slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_r[i] <= DATA_ZERO;
      end
    end else if (we_s) begin
      regs_r[i_addr_reg_dst] <= wb_data_s;
    end
  end

  // Halt latch and retired-slot counter; the stop slot itself is counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      halted_r <= 1'b0;
      count_r  <= 32'd0;
    end else if (advance_s) begin
      count_r <= count_r + 32'd1;
      if (is_stop_pipe) begin
        halted_r <= 1'b1;
      end
    end
  end

  // Debug read: samples the array before this edge's write, no bypass, ignores step/halt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dbg_r <= DATA_ZERO;
    end else if (i_dbg_addr == ADDR_ZERO) begin
      dbg_r <= DATA_ZERO;
    end else begin
      dbg_r <= regs_r[i_dbg_addr];
    end
  end

  assign o_wb_data       = wb_data_s;
  assign o_rs_data       = rs_data_s;
  assign o_rt_data       = rt_data_s;
  assign o_dbg_data      = dbg_r;
  assign os_halted       = halted_r;
  assign o_retired_count = count_r;

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Write-back stage and general-purpose register file of the pipelined MIPS core, sitting directly downstream of the MEM/WB pipeline latch. It consumes the latch outputs, selects the write-back value, commits it to a 32×32 register array and serves the decode stage's two read ports with same-cycle write-through bypass. It also latches the pipeline halt request, exposes a registered debug read port and counts retired slots for the debug unit.

## Interface
- NB_DATA, 32, data/register width
- N_REGS, 32, number of registers
- NB_ADDR, 5, register address width (log2 N_REGS)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- i_step  in  1  pipeline advance enable; write-back state changes only when high
- i_mem_data  in  NB_DATA  load data from MEM/WB
- i_alu_res  in  NB_DATA  ALU result from MEM/WB
- i_pc_to_reg  in  NB_DATA  return address (link) from MEM/WB
- i_addr_reg_dst  in  NB_ADDR  destination register
- is_RegWrite  in  1  register write request
- is_MemtoReg  in  1  select load data
- is_write_pc  in  1  select return address
- is_stop_pipe  in  1  halt instruction reached write-back
- i_rs_addr, i_rt_addr  in  NB_ADDR  decode read addresses
- o_rs_data, o_rt_data  out  NB_DATA  read data (combinational)
- i_dbg_addr  in  NB_ADDR  debug read address
- o_dbg_data  out  NB_DATA  debug read data (registered)
- o_wb_data  out  NB_DATA  selected write-back value (combinational)
- os_halted  out  1  halt latched
- o_retired_count  out  32  retired-slot counter

## Operation
- Write-back select: is_write_pc ? i_pc_to_reg : (is_MemtoReg ? i_mem_data : i_alu_res); is_write_pc has priority.
- Write enable we = rst & i_step & is_RegWrite & (i_addr_reg_dst != 0) & ~os_halted.
- On rising edge with we: regs[i_addr_reg_dst] <= o_wb_data.
- Register 0 is hardwired zero: never written, always reads 0 on every port.
- Read ports: addr 0 → 0; else if we and addr == i_addr_reg_dst → o_wb_data (bypass); else regs[addr]. rs and rt bypass independently, both may hit.
- Halt: when i_step & is_stop_pipe & ~os_halted, os_halted <= 1. A write requested in the same slot as the stop still commits. Once halted, all writes and counter updates are blocked until reset; i_step ignored.
- Retired counter: +1 on every edge where i_step & ~os_halted (stop slot included); wraps 0xFFFFFFFF → 0.
- Debug port: o_dbg_data <= (i_dbg_addr == 0) ? 0 : regs[i_dbg_addr] every cycle, independent of i_step and halt; no bypass.

## Timing
- Reset (rst=0 at edge): all regs 0, os_halted 0, o_retired_count 0, o_dbg_data 0. Reset overrides i_step and in-flight writes; applies mid-operation.
- Write latency: value enters array at edge; visible via bypass in the same cycle, via array from the next cycle.
- o_rs_data/o_rt_data/o_wb_data: zero-cycle combinational from inputs and array.
- o_dbg_data: one-cycle latency; reads the array pre-edge, so a write at edge N appears at o_dbg_data at edge N+1 when addressed at N+1.
- os_halted asserts the edge after the stop slot; the counter includes that slot.
- i_step low: no array, halt or counter change; reads still valid.

## Test plan
- Reset then write: rst=0 one cycle, check all outputs 0; then i_step=1, RegWrite=1, dst=5, alu=0x12345678 → next cycle regs[5]=0x12345678 via rs_addr=5 and dbg_addr=5 (dbg one cycle later), count=1.
- Source select: same slot dst=7 with mem=0xAAAA0000, alu=0x1, pc=0x40; MemtoReg=1 → 0xAAAA0000; write_pc=1 and MemtoReg=1 → 0x40.
- Bypass and r0: dst=3 write 0xDEAD with rs=rt=3 → both read 0xDEAD same cycle; dst=0 write 0xFFFF → reads of r0 stay 0, count still increments.
- Step gating: i_step=0 with RegWrite=1, dst=9, alu=0x99 → regs[9] unchanged, no bypass, count unchanged.
- Halt: stop_pipe=1 with RegWrite=1, dst=4, alu=0x44 → r4=0x44, os_halted=1 next cycle; further writes to r4=0x55 rejected, count frozen; rst=0 clears halt and registers.
- Counter wrap: drive 2^32 steps (or force count to 0xFFFFFFFF via long run) → next step gives 0.
